// File: rtl/cpu_wb_lsu_pkg.sv
// Shared types and constants for the write-back / load-store unit slice.
package cpu_wb_lsu_pkg;

  // Memory access size and signedness. D and WU are only meaningful when XLEN is 64.
  typedef enum logic [2:0] {
    MA_SIZE_B  = 3'd0,
    MA_SIZE_H  = 3'd1,
    MA_SIZE_W  = 3'd2,
    MA_SIZE_D  = 3'd3,
    MA_SIZE_BU = 3'd4,
    MA_SIZE_HU = 3'd5,
    MA_SIZE_WU = 3'd6
  } ma_size_t;

  typedef logic [4:0] regaddr_t;

  // Marker PC carried by bubbles; a captured bubble counts as an empty stage.
  localparam logic [63:0] NOP_PC = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/cpu_wb_lsu_load_extract.sv
// Combinational load-data aligner: shifts the word-aligned read data down by the
// byte offset, then sign- or zero-extends according to the access size.
module cpu_load_extract
  import cpu_wb_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  data_i,
  input  logic [OFF_W-1:0] offset_i,
  input  ma_size_t         size_i,
  output logic [XLEN-1:0]  result_o
);

  logic [XLEN-1:0] shifted_s;

  assign shifted_s = data_i >> {offset_i, 3'b000};

  // Truncate to the access size and extend back to XLEN.
  always_comb begin
    result_o = shifted_s;
    case (size_i)
      MA_SIZE_B:  result_o = XLEN'($signed(shifted_s[7:0]));
      MA_SIZE_H:  result_o = XLEN'($signed(shifted_s[15:0]));
      MA_SIZE_W:  result_o = XLEN'($signed(shifted_s[31:0]));
      MA_SIZE_BU: result_o = XLEN'(shifted_s[7:0]);
      MA_SIZE_HU: result_o = XLEN'(shifted_s[15:0]);
      MA_SIZE_WU: result_o = XLEN'(shifted_s[31:0]);
      MA_SIZE_D:  result_o = shifted_s;
      default:    result_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/cpu_wb_lsu.sv
// Registered write-back stage for a variable-latency data memory. Non-loads and
// loads whose data arrives in the accept cycle retire one cycle later; other
// loads park in WAIT_MEM until data, an error, or the timeout.
module cpu_wb_lsu
  import cpu_wb_lsu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REGADDR_W    = 5,
  parameter int CNT_W        = 64,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [31:0]               ir_i,
  input  logic                      load_i,
  input  ma_size_t                  ma_size_i,
  input  logic [$clog2(XLEN/8)-1:0] ma_offset_i,
  input  logic [XLEN-1:0]           wb_data_i,
  input  logic                      wb_valid_i,
  input  logic                      dmem_rvalid_i,
  input  logic [XLEN-1:0]           dmem_rdata_i,
  input  logic                      dmem_err_i,
  output logic [REGADDR_W-1:0]      wb_addr_o,
  output logic [XLEN-1:0]           wb_data_o,
  output logic                      wb_valid_o,
  output logic                      retire_o,
  output logic [CNT_W-1:0]          instret_o,
  output logic                      load_fault_o,
  output logic                      empty_o
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int TMO_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
  // Counter value seen on the last permitted WAIT_MEM cycle.
  localparam logic [TMO_W-1:0] TMO_LAST =
    (LOAD_TIMEOUT == 0) ? {TMO_W{1'b0}} : TMO_W'(LOAD_TIMEOUT - 1);

  wb_state_t            state_r;
  wb_state_t            state_next_s;
  logic                 accept_s;
  logic [REGADDR_W-1:0] rd_s;
  logic                 unused_ir_s;

  logic [REGADDR_W-1:0] cap_rd_r;
  ma_size_t             cap_size_r;
  logic [OFF_W-1:0]     cap_off_r;
  logic                 cap_wbv_r;
  logic [XLEN-1:0]      cap_pc_r;

  logic [TMO_W-1:0]     tmo_cnt_r;
  logic                 tmo_hit_s;

  ma_size_t             ext_size_s;
  logic [OFF_W-1:0]     ext_off_s;
  logic [XLEN-1:0]      ext_data_s;

  logic [REGADDR_W-1:0] wb_addr_next_s;
  logic [XLEN-1:0]      wb_data_next_s;
  logic                 wb_valid_next_s;
  logic                 retire_next_s;
  logic                 fault_next_s;

  assign rd_s        = REGADDR_W'(ir_i[11:7]);
  assign unused_ir_s = ^{ir_i[31:12], ir_i[6:0]};
  assign ready_o     = reset_ni && (state_r == IDLE);
  assign accept_s    = valid_i && ready_o;
  assign tmo_hit_s   = (LOAD_TIMEOUT != 0) && (state_r == WAIT_MEM) && (tmo_cnt_r == TMO_LAST);
  assign empty_o     = !reset_ni
                     || ((state_r == IDLE) && !wb_valid_o && !retire_o)
                     || (cap_pc_r == NOP_PC[XLEN-1:0]);

  // Extraction operands come from the MA stage in IDLE and from the capture registers while waiting.
  always_comb begin
    ext_size_s = ma_size_i;
    ext_off_s  = ma_offset_i;
    if (state_r == WAIT_MEM) begin
      ext_size_s = cap_size_r;
      ext_off_s  = cap_off_r;
    end else begin
      ext_size_s = ma_size_i;
      ext_off_s  = ma_offset_i;
    end
  end

  cpu_load_extract #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_extract (
    .data_i   (dmem_rdata_i),
    .offset_i (ext_off_s),
    .size_i   (ext_size_s),
    .result_o (ext_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: park only on a load whose data is not already here.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && load_i && !dmem_rvalid_i) begin
          state_next_s = WAIT_MEM;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_MEM: begin
        if (dmem_rvalid_i || tmo_hit_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_MEM;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: next values of the registered write-back, retire and fault outputs.
  always_comb begin
    wb_addr_next_s  = wb_addr_o;
    wb_data_next_s  = wb_data_o;
    wb_valid_next_s = 1'b0;
    retire_next_s   = 1'b0;
    fault_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          retire_next_s = 1'b0;
        end else if (!load_i) begin
          wb_addr_next_s  = rd_s;
          wb_data_next_s  = wb_data_i;
          wb_valid_next_s = wb_valid_i && (rd_s != {REGADDR_W{1'b0}});
          retire_next_s   = 1'b1;
        end else if (dmem_rvalid_i && dmem_err_i) begin
          fault_next_s = 1'b1;
        end else if (dmem_rvalid_i) begin
          wb_addr_next_s  = rd_s;
          wb_data_next_s  = ext_data_s;
          wb_valid_next_s = wb_valid_i && (rd_s != {REGADDR_W{1'b0}});
          retire_next_s   = 1'b1;
        end else begin
          retire_next_s = 1'b0;
        end
      end
      WAIT_MEM: begin
        if (dmem_rvalid_i && dmem_err_i) begin
          fault_next_s = 1'b1;
        end else if (dmem_rvalid_i) begin
          wb_addr_next_s  = cap_rd_r;
          wb_data_next_s  = ext_data_s;
          wb_valid_next_s = cap_wbv_r && (cap_rd_r != {REGADDR_W{1'b0}});
          retire_next_s   = 1'b1;
        end else if (tmo_hit_s) begin
          fault_next_s = 1'b1;
        end else begin
          fault_next_s = 1'b0;
        end
      end
      default: begin
        fault_next_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and retired-instruction counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wb_addr_o    <= {REGADDR_W{1'b0}};
      wb_data_o    <= {XLEN{1'b0}};
      wb_valid_o   <= 1'b0;
      retire_o     <= 1'b0;
      load_fault_o <= 1'b0;
      instret_o    <= {CNT_W{1'b0}};
    end else begin
      wb_addr_o    <= wb_addr_next_s;
      wb_data_o    <= wb_data_next_s;
      wb_valid_o   <= wb_valid_next_s;
      retire_o     <= retire_next_s;
      load_fault_o <= fault_next_s;
      if (retire_next_s) begin
        instret_o <= instret_o + CNT_W'(1);
      end
    end
  end

  // Capture the outstanding load's write-back context when it parks in WAIT_MEM.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cap_rd_r   <= {REGADDR_W{1'b0}};
      cap_size_r <= MA_SIZE_B;
      cap_off_r  <= {OFF_W{1'b0}};
      cap_wbv_r  <= 1'b0;
      cap_pc_r   <= {XLEN{1'b0}};
    end else if (accept_s && load_i && !dmem_rvalid_i) begin
      cap_rd_r   <= rd_s;
      cap_size_r <= ma_size_i;
      cap_off_r  <= ma_offset_i;
      cap_wbv_r  <= wb_valid_i;
      cap_pc_r   <= pc_i;
    end
  end

  // Count cycles spent waiting; cleared whenever WAIT_MEM is left or not yet entered.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r == WAIT_MEM) && (state_next_s == WAIT_MEM)) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_cpu_wb_lsu.sv
// Directed bench for cpu_wb_lsu: ALU write-back, load extraction, waited loads,
// error and timeout faults, rd==0, back-to-back retire count, async reset.
module tb_cpu_wb_lsu;
  import cpu_wb_lsu_pkg::*;

  localparam int XLEN         = 32;
  localparam int REGADDR_W    = 5;
  localparam int CNT_W        = 64;
  localparam int LOAD_TIMEOUT = 255;

  logic                 clk_i = 1'b0;
  logic                 reset_ni;
  logic                 valid_i;
  logic                 ready_o;
  logic [XLEN-1:0]      pc_i;
  logic [31:0]          ir_i;
  logic                 load_i;
  ma_size_t             ma_size_i;
  logic [1:0]           ma_offset_i;
  logic [XLEN-1:0]      wb_data_i;
  logic                 wb_valid_i;
  logic                 dmem_rvalid_i;
  logic [XLEN-1:0]      dmem_rdata_i;
  logic                 dmem_err_i;
  logic [REGADDR_W-1:0] wb_addr_o;
  logic [XLEN-1:0]      wb_data_o;
  logic                 wb_valid_o;
  logic                 retire_o;
  logic [CNT_W-1:0]     instret_o;
  logic                 load_fault_o;
  logic                 empty_o;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_ret;
  int               n_ret;

  typedef struct {
    ma_size_t    sz;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  cpu_wb_lsu #(
    .XLEN         (XLEN),
    .REGADDR_W    (REGADDR_W),
    .CNT_W        (CNT_W),
    .LOAD_TIMEOUT (LOAD_TIMEOUT)
  ) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .pc_i          (pc_i),
    .ir_i          (ir_i),
    .load_i        (load_i),
    .ma_size_i     (ma_size_i),
    .ma_offset_i   (ma_offset_i),
    .wb_data_i     (wb_data_i),
    .wb_valid_i    (wb_valid_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .dmem_err_i    (dmem_err_i),
    .wb_addr_o     (wb_addr_o),
    .wb_data_o     (wb_data_o),
    .wb_valid_o    (wb_valid_o),
    .retire_o      (retire_o),
    .instret_o     (instret_o),
    .load_fault_o  (load_fault_o),
    .empty_o       (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    valid_i       = 1'b0;
    load_i        = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_err_i    = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  task automatic set_op(input logic ld, input ma_size_t sz, input logic [1:0] off,
                        input logic [4:0] rd, input logic [31:0] d);
    valid_i     = 1'b1;
    load_i      = ld;
    ma_size_i   = sz;
    ma_offset_i = off;
    ir_i        = {20'h0, rd, 7'h13};
    wb_data_i   = d;
    wb_valid_i  = 1'b1;
    pc_i        = pc_i + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{MA_SIZE_B,  2'd2, 32'h0080_0000, 32'hFFFF_FF80};
    tbl[1] = '{MA_SIZE_BU, 2'd2, 32'h0080_0000, 32'h0000_0080};
    tbl[2] = '{MA_SIZE_B,  2'd1, 32'h0000_FE00, 32'hFFFF_FFFE};
    tbl[3] = '{MA_SIZE_B,  2'd3, 32'h7F00_0000, 32'h0000_007F};
    tbl[4] = '{MA_SIZE_HU, 2'd0, 32'h1234_8765, 32'h0000_8765};
    tbl[5] = '{MA_SIZE_H,  2'd0, 32'h1234_8765, 32'hFFFF_8765};
    tbl[6] = '{MA_SIZE_W,  2'd0, 32'h8000_0001, 32'h8000_0001};
    tbl[7] = '{MA_SIZE_H,  2'd3, 32'hAB00_0000, 32'h0000_00AB};

    reset_ni    = 1'b0;
    clr();
    pc_i        = 32'h0000_0100;
    ir_i        = 32'h0;
    wb_data_i   = 32'h0;
    wb_valid_i  = 1'b0;
    ma_size_i   = MA_SIZE_W;
    ma_offset_i = 2'd0;
    exp_ret     = 64'd0;

    // Reset state
    #12;
    check_eq("rst_ready", ready_o, 1'b0);
    check_eq("rst_empty", empty_o, 1'b1);
    check_eq("rst_wbv", wb_valid_o, 1'b0);
    check_eq("rst_addr", wb_addr_o, 5'd0);
    check_eq("rst_data", wb_data_o, 32'h0);
    check_eq("rst_retire", retire_o, 1'b0);
    check_eq("rst_fault", load_fault_o, 1'b0);
    check_eq("rst_instret", instret_o, 64'd0);
    reset_ni = 1'b1;
    tick();
    check_eq("idle_ready", ready_o, 1'b1);

    // ALU op, rd=5
    set_op(1'b0, MA_SIZE_W, 2'd0, 5'd5, 32'h0000_1234);
    tick();
    clr();
    exp_ret = exp_ret + 64'd1;
    check_eq("alu_addr", wb_addr_o, 5'd5);
    check_eq("alu_data", wb_data_o, 32'h0000_1234);
    check_eq("alu_wbv", wb_valid_o, 1'b1);
    check_eq("alu_retire", retire_o, 1'b1);
    check_eq("alu_instret", instret_o, exp_ret);
    check_eq("alu_empty", empty_o, 1'b0);
    tick();
    check_eq("alu_wbv_pulse", wb_valid_o, 1'b0);
    check_eq("alu_retire_pulse", retire_o, 1'b0);
    check_eq("alu_data_hold", wb_data_o, 32'h0000_1234);
    check_eq("alu_empty_after", empty_o, 1'b1);

    // Loads with data in the accept cycle
    for (int i = 0; i < 8; i++) begin
      set_op(1'b1, tbl[i].sz, tbl[i].off, 5'd6, 32'hDEAD_BEEF);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = tbl[i].rdata;
      tick();
      clr();
      exp_ret = exp_ret + 64'd1;
      check_eq($sformatf("ext%0d_data", i), wb_data_o, tbl[i].exp);
      check_eq($sformatf("ext%0d_retire", i), retire_o, 1'b1);
    end
    check_eq("ext_instret", instret_o, exp_ret);

    // LH waiting three cycles for data
    set_op(1'b1, MA_SIZE_H, 2'd2, 5'd7, 32'h0);
    tick();
    clr();
    check_eq("lh_wait_empty", empty_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("lh_wait_ready%0d", k), ready_o, 1'b0);
      check_eq($sformatf("lh_wait_retire%0d", k), retire_o, 1'b0);
      if (k < 2) tick();
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h8001_0000;
    tick();
    clr();
    exp_ret = exp_ret + 64'd1;
    check_eq("lh_data", wb_data_o, 32'hFFFF_8001);
    check_eq("lh_addr", wb_addr_o, 5'd7);
    check_eq("lh_wbv", wb_valid_o, 1'b1);
    check_eq("lh_retire", retire_o, 1'b1);
    check_eq("lh_ready", ready_o, 1'b1);
    check_eq("lh_instret", instret_o, exp_ret);

    // Load with dmem error
    set_op(1'b1, MA_SIZE_W, 2'd0, 5'd8, 32'h0);
    tick();
    clr();
    dmem_rvalid_i = 1'b1;
    dmem_err_i    = 1'b1;
    dmem_rdata_i  = 32'h5555_5555;
    tick();
    clr();
    check_eq("err_fault", load_fault_o, 1'b1);
    check_eq("err_wbv", wb_valid_o, 1'b0);
    check_eq("err_retire", retire_o, 1'b0);
    check_eq("err_instret", instret_o, exp_ret);
    check_eq("err_data_hold", wb_data_o, 32'hFFFF_8001);
    check_eq("err_addr_hold", wb_addr_o, 5'd7);
    check_eq("err_ready", ready_o, 1'b1);
    tick();
    check_eq("err_fault_pulse", load_fault_o, 1'b0);

    // Load timeout: fault after LOAD_TIMEOUT waiting cycles
    set_op(1'b1, MA_SIZE_W, 2'd0, 5'd9, 32'h0);
    tick();
    clr();
    repeat (LOAD_TIMEOUT - 1) tick();
    check_eq("tmo_pre_fault", load_fault_o, 1'b0);
    check_eq("tmo_pre_ready", ready_o, 1'b0);
    tick();
    check_eq("tmo_fault", load_fault_o, 1'b1);
    check_eq("tmo_ready", ready_o, 1'b1);
    check_eq("tmo_wbv", wb_valid_o, 1'b0);
    check_eq("tmo_retire", retire_o, 1'b0);
    check_eq("tmo_instret", instret_o, exp_ret);
    tick();
    check_eq("tmo_fault_pulse", load_fault_o, 1'b0);

    // Write to rd=0 retires without a register write
    set_op(1'b0, MA_SIZE_W, 2'd0, 5'd0, 32'h0000_0077);
    tick();
    clr();
    exp_ret = exp_ret + 64'd1;
    check_eq("rd0_wbv", wb_valid_o, 1'b0);
    check_eq("rd0_retire", retire_o, 1'b1);
    check_eq("rd0_instret", instret_o, exp_ret);

    // 100 back-to-back ALU ops
    n_ret = 0;
    for (int i = 0; i < 100; i++) begin
      set_op(1'b0, MA_SIZE_W, 2'd0, 5'd3, 32'd1000 + 32'(i));
      tick();
      if (retire_o) n_ret++;
    end
    clr();
    exp_ret = exp_ret + 64'd100;
    check_eq("b2b_retires", 64'(n_ret), 64'd100);
    check_eq("b2b_instret", instret_o, exp_ret);
    check_eq("b2b_data", wb_data_o, 32'd1099);
    check_eq("b2b_addr", wb_addr_o, 5'd3);

    // Stray rvalid in IDLE is ignored
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1111_1111;
    tick();
    clr();
    check_eq("stray_retire", retire_o, 1'b0);
    check_eq("stray_wbv", wb_valid_o, 1'b0);
    check_eq("stray_fault", load_fault_o, 1'b0);
    check_eq("stray_instret", instret_o, exp_ret);
    check_eq("stray_data_hold", wb_data_o, 32'd1099);

    // Async reset while a load waits
    set_op(1'b1, MA_SIZE_W, 2'd0, 5'd10, 32'h0);
    tick();
    clr();
    check_eq("mid_wait_ready", ready_o, 1'b0);
    #1;
    reset_ni = 1'b0;
    #1;
    check_eq("arst_addr", wb_addr_o, 5'd0);
    check_eq("arst_data", wb_data_o, 32'h0);
    check_eq("arst_instret", instret_o, 64'd0);
    check_eq("arst_ready", ready_o, 1'b0);
    check_eq("arst_empty", empty_o, 1'b1);
    reset_ni = 1'b1;
    tick();
    check_eq("arst_idle_ready", ready_o, 1'b1);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h2222_2222;
    tick();
    clr();
    check_eq("late_rv_retire", retire_o, 1'b0);
    check_eq("late_rv_wbv", wb_valid_o, 1'b0);
    check_eq("late_rv_fault", load_fault_o, 1'b0);
    check_eq("late_rv_instret", instret_o, 64'd0);
    check_eq("late_rv_data", wb_data_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
